cl_frame_sequencer: RTL and testbench

Frame/line timing controller between the pixel FIFO read port and the CameraLink transmitter. It pulls 16-bit pixels from the FIFO only while a line is active and frames them into FVAL/LVAL/DVAL with programmable horizontal and vertical blanking. Frames start either on an external sync edge or in free-run mode. It also reports FIFO underruns and counts completed frames.

---
 rtl/cl_seq_pkg.sv | 27 ++
 rtl/cl_sync_edge.sv | 26 ++
 rtl/cl_frame_sequencer.sv | 139 +++++++++++++
 tb/tb_cl_frame_sequencer.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cl_seq_pkg.sv
// Shared types and defaults for the CameraLink frame sequencer.
// Holds the FSM state enum, default geometry and the output pipeline depth.
package cl_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_SYNC = 3'd1,
    LINE      = 3'd2,
    HBL       = 3'd3,
    VBL       = 3'd4
  } seq_state_t;

  typedef struct packed {
    logic fval;
    logic lval;
    logic dval;
  } vld_t;

  localparam int DEF_LINE_PIX = 640;
  localparam int DEF_LINES    = 480;
  localparam int DEF_HBLANK   = 16;
  localparam int DEF_VBLANK   = 4;

  // FIFO read latency plus the output register
  localparam int PIPE_DEPTH   = 2;

endpackage

// File: rtl/cl_sync_edge.sv
// 2-FF synchroniser for an asynchronous level, plus a registered rising-edge pulse.
// Latency: input edge to rise pulse is 3 clk; no backpressure.
module cl_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic meta, sync_q, sync_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= 1'b0;
      sync_q <= 1'b0;
      sync_d <= 1'b0;
      rise   <= 1'b0;
    end else begin
      meta   <= async_in;
      sync_q <= meta;
      sync_d <= sync_q;
      rise   <= sync_q & ~sync_d;
    end
  end

endmodule

// File: rtl/cl_frame_sequencer.sv
// Frame/line timing: pulls FIFO pixels into FVAL/LVAL/DVAL with programmable blanking; CL_UNDERRUN_CNT_EN adds underrun_cnt.
// Latency: read_en to pix/fval/lval/dval is 2 clk; FIFO empty stalls the line (lval held, dval gap).
module cl_frame_sequencer
  import cl_seq_pkg::*;
#(
  parameter int LINE_PIX = DEF_LINE_PIX,
  parameter int LINES    = DEF_LINES,
  parameter int HBLANK   = DEF_HBLANK,
  parameter int VBLANK   = DEF_VBLANK,
  parameter int CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        syncOrNot,
  input  logic        sync_out,
  input  logic        empty,
  input  logic [15:0] dat,
  output logic        read_en,
  output logic [15:0] pix,
  output logic        fval,
  output logic        lval,
  output logic        dval,
  output logic [15:0] frame_cnt,
  output logic        underrun,
`ifdef CL_UNDERRUN_CNT_EN
  output logic [15:0] underrun_cnt,
`endif
  input  logic        clr_err,
  output logic        busy
);

  localparam logic [CNT_W-1:0] PIX_MAX   = CNT_W'(LINE_PIX);
  localparam logic [CNT_W-1:0] PIX_LAST  = CNT_W'(LINE_PIX - 1);
  localparam logic [CNT_W-1:0] LINE_LAST = CNT_W'(LINES - 1);
  localparam logic [CNT_W-1:0] HBL_LAST  = CNT_W'(HBLANK - 1);
  localparam logic [CNT_W-1:0] VBL_LAST  = CNT_W'(VBLANK - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  seq_state_t             state, state_nxt;
  logic [CNT_W-1:0]       pix_cnt, line_cnt, blk_cnt;
  logic                   sync_rise, stall, line_done;
  vld_t                   vld_cur;
  vld_t [PIPE_DEPTH-1:0]  vld_pipe;

  cl_sync_edge u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (sync_out),
    .rise     (sync_rise)
  );

  always_comb begin
    state_nxt = state;
    read_en   = 1'b0;
    stall     = 1'b0;
    if (state == LINE && pix_cnt < PIX_MAX) begin
      read_en = ~empty;
      stall   = empty;
    end
    line_done    = read_en && (pix_cnt == PIX_LAST);
    vld_cur.fval = (state == LINE) || (state == HBL);
    vld_cur.lval = (state == LINE);
    vld_cur.dval = read_en;

    case (state)
      IDLE:      if (en) state_nxt = syncOrNot ? WAIT_SYNC : LINE;
      WAIT_SYNC: begin
        if (sync_rise)  state_nxt = LINE;
        else if (!en)   state_nxt = IDLE;
      end
      LINE:      if (line_done) state_nxt = (line_cnt == LINE_LAST) ? VBL : HBL;
      HBL:       if (blk_cnt == HBL_LAST) state_nxt = LINE;
      // run mode is re-sampled only here, at the frame boundary
      VBL: begin
        if (blk_cnt == VBL_LAST) begin
          if (!en)            state_nxt = IDLE;
          else if (syncOrNot) state_nxt = WAIT_SYNC;
          else                state_nxt = LINE;
        end
      end
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt   <= '0;
      line_cnt  <= '0;
      blk_cnt   <= '0;
      frame_cnt <= '0;
      underrun  <= 1'b0;
    end else begin
      if (state != LINE)  pix_cnt <= '0;
      else if (read_en)   pix_cnt <= pix_cnt + CNT_ONE;

      if (state_nxt != state)                 blk_cnt <= '0;
      else if (state == HBL || state == VBL)  blk_cnt <= blk_cnt + CNT_ONE;

      // line index survives HBL, restarts whenever a frame is not in progress
      if (state == HBL && state_nxt == LINE)  line_cnt <= line_cnt + CNT_ONE;
      else if (state != LINE && state != HBL) line_cnt <= '0;

      if (state == LINE && state_nxt == VBL)  frame_cnt <= frame_cnt + 16'd1;

      if (clr_err)    underrun <= 1'b0;
      else if (stall) underrun <= 1'b1;
    end
  end

`ifdef CL_UNDERRUN_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 underrun_cnt <= '0;
    else if (clr_err)                        underrun_cnt <= '0;
    else if (stall && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      pix      <= '0;
    end else begin
      vld_pipe <= {vld_pipe[PIPE_DEPTH-2:0], vld_cur};
      if (vld_pipe[PIPE_DEPTH-2].dval) pix <= dat;
    end
  end

  assign fval = vld_pipe[PIPE_DEPTH-1].fval;
  assign lval = vld_pipe[PIPE_DEPTH-1].lval;
  assign dval = vld_pipe[PIPE_DEPTH-1].dval;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_cl_frame_sequencer.sv
// Bench for cl_frame_sequencer: behavioural frame model checked every cycle plus directed scenarios.
module tb_cl_frame_sequencer;

  localparam int LP = 4;
  localparam int LN = 2;
  localparam int HB = 2;
  localparam int VB = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        sync_sel = 1'b0;
  logic        sync_out = 1'b0;
  logic        empty = 1'b0;
  logic        clr_err = 1'b0;
  logic [15:0] dat = 16'h0;
  logic        read_en, fval, lval, dval, underrun, busy;
  logic [15:0] pix, frame_cnt;
`ifdef CL_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  always #5 clk = ~clk;

  cl_frame_sequencer #(
    .LINE_PIX (LP), .LINES (LN), .HBLANK (HB), .VBLANK (VB), .CNT_W (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .syncOrNot    (sync_sel),
    .sync_out     (sync_out),
    .empty        (empty),
    .dat          (dat),
    .read_en      (read_en),
    .pix          (pix),
    .fval         (fval),
    .lval         (lval),
    .dval         (dval),
    .frame_cnt    (frame_cnt),
    .underrun     (underrun),
`ifdef CL_UNDERRUN_CNT_EN
    .underrun_cnt (underrun_cnt),
`endif
    .clr_err      (clr_err),
    .busy         (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Behavioural model: a frame is LN lines of LP reads, HB idle clocks between
  // lines, VB idle clocks after the last line; outputs trail by two clocks.
  typedef enum int {PH_IDLE, PH_ARMED, PH_ACTIVE, PH_HGAP, PH_VGAP} phase_t;
  typedef struct {bit f; bit l; bit d; int p;} exp_t;

  phase_t      ph;
  exp_t        pipe[2];
  int          reads_left, lines_left, gap_left;
  bit [15:0]   m_frames;
  bit          m_under;
  int          m_ucnt;
  int          m_src = 1;
  bit          samp[4];
  bit          force_req = 1'b0;

  // FIFO emulator and observation records
  bit          rd_q;
  int          src = 1;
  int          rd_total = 0;
  int          out_pix[$];
  int          runs[$];
  int          lval_gaps[$];
  int          fval_gaps[$];
  bit          dpat[$];
  int          first_dval = -1;
  int          cur_run, lo_run, flo_run;
  bit          prev_l, prev_f, seen_f;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic model_reset();
    ph = PH_IDLE;
    for (int i = 0; i < 2; i++) pipe[i] = '{0, 0, 0, 0};
    for (int i = 0; i < 4; i++) samp[i] = 1'b0;
    reads_left = 0; lines_left = 0; gap_left = 0;
    m_frames = '0; m_under = 1'b0; m_ucnt = 0;
    cur_run = 0; lo_run = 0; flo_run = 0;
    prev_l = 1'b0; prev_f = 1'b0; seen_f = 1'b0;
  endtask

  task automatic start_frame();
    ph = PH_ACTIVE;
    reads_left = LP;
    lines_left = LN;
  endtask

  task automatic monitor();
    bit   e_read, edge_now, stall;
    exp_t cur;
    if (rst) begin
      model_reset();
      rd_q = 1'b0;
      chk("rst read_en", read_en, 0);
      chk("rst fval", fval, 0);
      chk("rst lval", lval, 0);
      chk("rst dval", dval, 0);
      chk("rst pix", pix, 0);
      chk("rst busy", busy, 0);
      chk("rst frame_cnt", frame_cnt, 0);
      chk("rst underrun", underrun, 0);
      return;
    end
    if (force_req) m_frames = 16'hFFFF;
    e_read   = (ph == PH_ACTIVE) && !empty;
    stall    = (ph == PH_ACTIVE) && empty;
    // sync_out reaches the FSM as an edge seen two and three samples back
    edge_now = samp[2] && !samp[3];

    chk("read_en", read_en, e_read);
    chk("busy", busy, ph != PH_IDLE);
    chk("fval", fval, pipe[1].f);
    chk("lval", lval, pipe[1].l);
    chk("dval", dval, pipe[1].d);
    if (pipe[1].d) chk("pix", pix, pipe[1].p);
    chk("frame_cnt", frame_cnt, m_frames);
    chk("underrun", underrun, m_under);
`ifdef CL_UNDERRUN_CNT_EN
    chk("underrun_cnt", underrun_cnt, m_ucnt);
`endif

    if (dval) out_pix.push_back(int'(pix));
    if (lval) begin
      cur_run++;
      dpat.push_back(dval);
      if (!prev_l && prev_f) lval_gaps.push_back(lo_run);
      lo_run = 0;
    end else begin
      if (prev_l) runs.push_back(cur_run);
      cur_run = 0;
      lo_run++;
    end
    if (fval) begin
      if (!prev_f && seen_f) fval_gaps.push_back(flo_run);
      flo_run = 0;
      seen_f = 1'b1;
    end else flo_run++;
    if (dval && first_dval < 0) first_dval = cyc;
    prev_l = lval;
    prev_f = fval;
    rd_q = read_en;
    if (read_en) rd_total++;

    cur.f = (ph == PH_ACTIVE) || (ph == PH_HGAP);
    cur.l = (ph == PH_ACTIVE);
    cur.d = e_read;
    cur.p = e_read ? m_src : 0;
    if (e_read) m_src++;
    pipe[1] = pipe[0];
    pipe[0] = cur;

    if (clr_err) begin m_under = 1'b0; m_ucnt = 0; end
    else if (stall) begin
      m_under = 1'b1;
      if (m_ucnt < 65535) m_ucnt++;
    end

    case (ph)
      PH_IDLE:  if (en) begin if (sync_sel) ph = PH_ARMED; else start_frame(); end
      PH_ARMED: if (edge_now) start_frame(); else if (!en) ph = PH_IDLE;
      PH_ACTIVE: if (e_read) begin
        reads_left--;
        if (reads_left == 0) begin
          lines_left--;
          if (lines_left == 0) begin ph = PH_VGAP; gap_left = VB; m_frames++; end
          else begin ph = PH_HGAP; gap_left = HB; end
        end
      end
      PH_HGAP: begin
        gap_left--;
        if (gap_left == 0) begin ph = PH_ACTIVE; reads_left = LP; end
      end
      PH_VGAP: begin
        gap_left--;
        if (gap_left == 0) begin
          if (!en) ph = PH_IDLE;
          else if (sync_sel) ph = PH_ARMED;
          else start_frame();
        end
      end
      default: ph = PH_IDLE;
    endcase

    samp[3] = samp[2];
    samp[2] = samp[1];
    samp[1] = samp[0];
    samp[0] = sync_out;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    monitor();
    @(posedge clk);
    #1;
    if (rd_q) begin
      dat = 16'(src);
      src++;
    end
  endtask

  task automatic clear_records();
    out_pix.delete(); runs.delete(); lval_gaps.delete();
    fval_gaps.delete(); dpat.delete();
    first_dval = -1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clear_records();
  endtask

  task automatic run_until_idle(input int maxc, input string nm);
    int n = 0;
    while (busy !== 1'b0 && n < maxc) begin tick(); n++; end
    chk(nm, busy, 0);
  endtask

  task automatic wait_reads(input int target, input int maxc, input string nm);
    int n = 0;
    while (rd_total < target && n < maxc) begin tick(); n++; end
    chk(nm, rd_total >= target, 1);
  endtask

  task automatic wait_frame_cnt(input logic [15:0] v, input int maxc, input string nm);
    int n = 0;
    while (frame_cnt !== v && n < maxc) begin tick(); n++; end
    chk(nm, frame_cnt, v);
  endtask

  initial begin
    int n, c0, rd0, pat;
    model_reset();
    tick();
    do_reset();

    // Free-run: two frames of sequential pixels
    en = 1'b1; sync_sel = 1'b0; empty = 1'b0;
    n = 0;
    while (out_pix.size() < 16 && n < 200) begin tick(); n++; end
    chk("A pixel count", out_pix.size() >= 16, 1);
    en = 1'b0;
    run_until_idle(100, "A idle timeout");
    for (int i = 0; i < 16; i++) chk("A pixel value", qget(out_pix, i), i + 1);
    for (int i = 0; i < 4; i++) chk("A lval run", qget(runs, i), LP);
    chk("A hblank", qget(lval_gaps, 0), HB);
    chk("A vblank", qget(fval_gaps, 0), VB);
    chk("A underrun", underrun, 0);

    // Underrun: two empty clocks after the second read of line 1
    do_reset();
    rd0 = rd_total;
    en = 1'b1;
    wait_reads(rd0 + 2, 50, "B read timeout");
    empty = 1'b1;
    tick();
    tick();
    empty = 1'b0;
    en = 1'b0;
    run_until_idle(100, "B idle timeout");
    chk("B lval run", qget(runs, 0), 6);
    pat = 0;
    for (int i = 0; i < 6; i++) pat = (pat << 1) | ((i < dpat.size()) ? int'(dpat[i]) : 0);
    chk("B dval pattern", pat, 32'b110011);
    chk("B underrun sticky", underrun, 1);
`ifdef CL_UNDERRUN_CNT_EN
    chk("B underrun_cnt", underrun_cnt, 2);
`endif
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    tick();
    chk("B underrun cleared", underrun, 0);

    // Sync mode: one frame per pulse, mid-frame pulse dropped
    do_reset();
    en = 1'b1; sync_sel = 1'b1;
    repeat (4) tick();
    chk("C armed busy", busy, 1);
    chk("C no frame yet", frame_cnt, 0);
    c0 = cyc;
    sync_out = 1'b1;
    repeat (5) tick();
    sync_out = 1'b0;
    n = 0;
    while (first_dval < 0 && n < 50) begin tick(); n++; end
    // edge sampled at the next clock, dval five clocks after that
    chk("C edge to dval", first_dval - c0, 7);
    tick();
    sync_out = 1'b1;
    repeat (5) tick();
    sync_out = 1'b0;
    repeat (40) tick();
    chk("C one frame", frame_cnt, 1);
    chk("C lines", runs.size(), LN);
    chk("C rearmed", busy, 1);
    en = 1'b0;
    run_until_idle(10, "C idle timeout");

    // Disable mid-frame: the frame still completes
    do_reset();
    sync_sel = 1'b0;
    rd0 = rd_total;
    en = 1'b1;
    wait_reads(rd0 + 2, 50, "D read timeout");
    en = 1'b0;
    run_until_idle(100, "D idle timeout");
    chk("D frame done", frame_cnt, 1);
    chk("D lines", runs.size(), LN);
    repeat (10) tick();
    chk("D read_en quiet", read_en, 0);
    chk("D busy", busy, 0);

    // Reset mid-line clears immediately, then a fresh frame
    do_reset();
    rd0 = rd_total;
    en = 1'b1;
    wait_reads(rd0 + 3, 50, "E read timeout");
    chk("E lval before reset", lval, 1);
    rst = 1'b1;
    #1;
    chk("E fval", fval, 0);
    chk("E lval", lval, 0);
    chk("E dval", dval, 0);
    chk("E pix", pix, 0);
    chk("E read_en", read_en, 0);
    chk("E busy", busy, 0);
    tick();
    clear_records();
    rst = 1'b0;
    tick();
    chk("E frame_cnt", frame_cnt, 0);
    wait_frame_cnt(16'd1, 100, "E frame timeout");
    en = 1'b0;
    run_until_idle(100, "E idle timeout");
    chk("E line0", qget(runs, 0), LP);
    chk("E line1", qget(runs, 1), LP);

    // Frame counter wrap
    force_req = 1'b1;
    force dut.frame_cnt = 16'hFFFF;
    tick();
    release dut.frame_cnt;
    force_req = 1'b0;
    chk("F preset", frame_cnt, 16'hFFFF);
    en = 1'b1;
    wait_frame_cnt(16'd0, 100, "F wrap");
    en = 1'b0;
    run_until_idle(100, "F idle timeout");
    chk("F wrapped", frame_cnt, 0);

    // Randomized traffic against the model
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      empty   = ($urandom_range(0, 9) < 2);
      clr_err = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 63) == 0)  en = ~en;
      if ($urandom_range(0, 127) == 0) sync_sel = ~sync_sel;
      if ($urandom_range(0, 5) == 0)   sync_out = ~sync_out;
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0; empty = 1'b0; clr_err = 1'b0; en = 1'b0;
    run_until_idle(200, "G idle timeout");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
